// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample, mid-bit and end-of-bit ticks from an integer+fraction divisor.
// Latency: ticks are a same-cycle decode of the registered cycle counter; div_err is registered (one cycle).
// Backpressure: none; enable freezes all state, and load/restart act in the cycle they are seen.
module baud_gen_frac #(
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 163,
  parameter int DEF_FRAC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              restart,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              div_err
);

  // One extra bit so that last = div_int_q - 1 + ext never overflows at the top divisor.
  localparam int CNT_W = INT_W + 1;
  // OVS is a power of two, so os_cnt wraps naturally at OVS.
  localparam int OS_W  = $clog2(OVS);

  localparam logic [INT_W-1:0]  DEF_INT_V  = INT_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC_V = FRAC_W'(DEF_FRAC);
  localparam logic [INT_W-1:0]  MIN_DIV    = INT_W'(2);
  localparam logic [OS_W-1:0]   OS_LAST    = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]   OS_MID     = OS_W'(OVS / 2 - 1);

  // Active divisor
  logic [INT_W-1:0]  div_int_q;
  logic [FRAC_W-1:0] div_frac_q;

  // Phase state
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  last;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [OS_W-1:0]   os_cnt;
  logic              div_err_q;

  // Decoded controls
  logic              load_ok;
  logic              load_bad;
  logic              clear;
  logic              period_end;
  logic              os_fire;
  logic [FRAC_W:0]   frac_sum;

  // A divisor below 2 would give a period of 0 or 1 cycles, which the
  // counter cannot represent, so such a load is refused and flagged.
  assign load_ok  = div_load && (div_int >= MIN_DIV);
  assign load_bad = div_load && !load_ok;

  // Both an accepted load and a restart realign phase; a refused load does not.
  assign clear = load_ok || restart;

  // A period lasts div_int_q cycles, stretched by one when the previous
  // fractional accumulation carried.
  assign last       = {1'b0, div_int_q} - CNT_W'(1) + {{INT_W{1'b0}}, ext};
  assign period_end = (cnt == last);

  // Internal tick: used to advance state. The outputs additionally gate on
  // resetn so nothing escapes while reset is held, independent of flop state.
  assign os_fire = enable && !clear && period_end;

  assign tick_os  = resetn && os_fire;
  assign tick_bit = resetn && os_fire && (os_cnt == OS_LAST);
  assign tick_mid = resetn && os_fire && (os_cnt == OS_MID);
  assign div_err  = div_err_q;

  // Carry out of the fractional add decides whether the next period is stretched.
  assign frac_sum = {1'b0, acc} + {1'b0, div_frac_q};

  // Active divisor: replaced only by an accepted load, restored to defaults by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_int_q  <= DEF_INT_V;
      div_frac_q <= DEF_FRAC_V;
    end else if (load_ok) begin
      div_int_q  <= div_int;
      div_frac_q <= div_frac;
    end
  end

  // Cycle counter: runs 0..last while enabled, wraps on the oversample tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (period_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Fractional accumulator: advances once per oversample period; a clear
  // zeroes ext so the first period after it is exactly div_int_q cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (os_fire) begin
      acc <= frac_sum[FRAC_W-1:0];
      ext <= frac_sum[FRAC_W];
    end
  end

  // Oversample counter: position within the current bit, modulo OVS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      os_cnt <= '0;
    end else if (clear) begin
      os_cnt <= '0;
    end else if (os_fire) begin
      os_cnt <= os_cnt + OS_W'(1);
    end
  end

  // Refused-load flag: a single-cycle pulse in the cycle after the attempt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= load_bad;
    end
  end

  // Tick relationships the TX/RX shifters rely on.
  a_bit_is_os: assert property (@(posedge clk) tick_bit |-> tick_os);
  a_mid_bit_excl: assert property (@(posedge clk) !(tick_mid && tick_bit));
  a_quiet_in_reset: assert property (@(posedge clk) !resetn |-> !(tick_os || tick_mid || tick_bit));

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed divisor table, hand-written corner sequences, random traffic.
// Latency: every cycle's outputs are compared against an arithmetic reference model before the next edge.
// Backpressure: not applicable; the bench drives one input set per cycle.
module tb_baud_gen_frac;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              enable;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              restart;
  logic              tick_os;
  logic              tick_mid;
  logic              tick_bit;
  logic              div_err;

  baud_gen_frac #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(163), .DEF_FRAC(0)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load), .restart(restart),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit), .div_err(div_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: elapsed enabled cycles and ticks since the last phase
  // clear. The n-th tick after a clear lands at n*I + floor((n-1)*F / 2^FRAC_W).
  longint m_int  = 163;
  longint m_frac = 0;
  longint m_e    = 0;
  longint m_k    = 0;
  bit     m_errp = 1'b0;

  // Outputs seen in the most recent cycle
  bit obs_os, obs_mid, obs_bit, obs_err;

  typedef struct {
    int di;
    int df;
    int first_os;
    int first_mid;
    int first_bit;
  } vec_t;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint tick_time(longint n);
    return n * m_int + (((n - 1) * m_frac) >> FRAC_W);
  endfunction

  // One clock cycle: drive at negedge, compare settled outputs to the model, advance the model.
  task automatic cycle(bit rn, bit en, bit ld, int di, int df, bit rs);
    bit e_os, e_mid, e_bit, e_err;
    logic [3:0] got, want;
    @(negedge clk);
    resetn   = rn;
    enable   = en;
    div_load = ld;
    div_int  = di[INT_W-1:0];
    div_frac = df[FRAC_W-1:0];
    restart  = rs;
    #2;
    e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0; e_err = 1'b0;
    if (!rn) begin
      m_int = 163; m_frac = 0; m_e = 0; m_k = 0; m_errp = 1'b0;
    end else begin
      e_err  = m_errp;
      m_errp = ld && (di < 2);
      if (ld && di >= 2) begin
        m_int = di; m_frac = df; m_e = 0; m_k = 0;
      end else if (rs) begin
        m_e = 0; m_k = 0;
      end else if (en) begin
        m_e++;
        if (m_e == tick_time(m_k + 1)) begin
          m_k++;
          e_os  = 1'b1;
          e_mid = (m_k % OVS) == (OVS / 2);
          e_bit = (m_k % OVS) == 0;
        end
      end
    end
    obs_os = tick_os; obs_mid = tick_mid; obs_bit = tick_bit; obs_err = div_err;
    got  = {tick_os, tick_mid, tick_bit, div_err};
    want = {e_os, e_mid, e_bit, e_err};
    check("cycle_outputs{os,mid,bit,err}", got, want);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Cycles until the next tick_os (the hit cycle counts); -1 if the bound expires.
  task automatic run_until_os(int bound, output int n);
    n = 0;
    while (n < bound) begin
      idle();
      n++;
      if (obs_os) return;
    end
    n = -1;
  endtask

  // Cycle offsets of the first tick_os, tick_mid and tick_bit; -1 for any not seen within bound.
  task automatic measure(int bound, output int f_os, output int f_mid, output int f_bit);
    int n;
    n = 0; f_os = -1; f_mid = -1; f_bit = -1;
    while (f_bit < 0 && n < bound) begin
      idle();
      n++;
      if (obs_os && f_os < 0) f_os = n;
      if (obs_mid && f_mid < 0) f_mid = n;
      if (obs_bit) f_bit = n;
    end
  endtask

  initial begin
    vec_t vt[5];
    int f_os, f_mid, f_bit, n, seen;
    bit rn, en, ld, rs;
    int di, df;

    resetn = 1'b0; enable = 1'b0; div_load = 1'b0; restart = 1'b0;
    div_int = '0; div_frac = '0;

    // 10/8: carry first appears at the second tick, so period three is the first 11.
    vt[0] = '{di: 163, df: 0,  first_os: 163, first_mid: 1304, first_bit: 2608};
    vt[1] = '{di: 10,  df: 8,  first_os: 10,  first_mid: 83,   first_bit: 167};
    vt[2] = '{di: 2,   df: 15, first_os: 2,   first_mid: 22,   first_bit: 46};
    vt[3] = '{di: 5,   df: 1,  first_os: 5,   first_mid: 40,   first_bit: 80};
    vt[4] = '{di: 7,   df: 4,  first_os: 7,   first_mid: 57,   first_bit: 115};

    // Reset state, then defaults after release
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("reset_ticks_zero", {obs_os, obs_mid, obs_bit, obs_err}, 0);
    measure(3000, f_os, f_mid, f_bit);
    check("default_first_os", f_os, 163);
    check("default_first_mid", f_mid, 1304);
    check("default_first_bit", f_bit, 2608);
    run_until_os(400, n);
    check("default_spacing", n, 163);

    // Divisor table: load, then time the first os/mid/bit ticks from the load cycle
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, vt[i].di, vt[i].df, 1'b0);
      check("load_cycle_no_tick", obs_os, 0);
      measure(4000, f_os, f_mid, f_bit);
      check($sformatf("tbl%0d_first_os", i), f_os, vt[i].first_os);
      check($sformatf("tbl%0d_first_mid", i), f_mid, vt[i].first_mid);
      check($sformatf("tbl%0d_first_bit", i), f_bit, vt[i].first_bit);
    end

    // Back to defaults for the corner sequences
    cycle(1'b1, 1'b1, 1'b1, 163, 0, 1'b0);

    // Refused load mid-period: error pulse next cycle only, phase untouched
    run_until_os(400, n);
    repeat (40) idle();
    cycle(1'b1, 1'b1, 1'b1, 1, 3, 1'b0);
    idle();
    check("bad_load_err_pulse", obs_err, 1);
    idle();
    check("bad_load_err_single", obs_err, 0);
    run_until_os(400, n);
    check("bad_load_phase_kept", n, 120);

    // Refused load with div_int=0 together with restart: restart still clears
    run_until_os(400, n);
    repeat (30) idle();
    cycle(1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
    check("restart_bad_load_no_tick", obs_os, 0);
    idle();
    check("restart_bad_load_err", obs_err, 1);
    run_until_os(400, n);
    check("restart_bad_load_phase", n, 162);

    // Restart at cnt=80: next tick_os 163 cycles later, bit counter realigned
    run_until_os(400, n);
    repeat (80) idle();
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    check("restart_no_tick", obs_os, 0);
    measure(3000, f_os, f_mid, f_bit);
    check("restart_first_os", f_os, 163);
    check("restart_first_mid", f_mid, 1304);
    check("restart_first_bit", f_bit, 2608);

    // Enable low for 50 cycles at cnt=100: tick slips by exactly 50
    run_until_os(400, n);
    repeat (100) idle();
    seen = 0;
    repeat (50) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      seen += int'(obs_os) + int'(obs_mid) + int'(obs_bit);
    end
    check("disabled_no_ticks", seen, 0);
    run_until_os(400, n);
    check("reenable_resume", n, 63);

    // Reset mid-period after a 10/8 load: ticks quiet, defaults restored
    cycle(1'b1, 1'b1, 1'b1, 10, 8, 1'b0);
    repeat (5) idle();
    seen = 0;
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      seen += int'(obs_os) + int'(obs_mid) + int'(obs_bit);
    end
    check("mid_reset_quiet", seen, 0);
    measure(3000, f_os, f_mid, f_bit);
    check("post_reset_first_os", f_os, 163);
    check("post_reset_first_bit", f_bit, 2608);
    run_until_os(400, n);
    check("post_reset_spacing", n, 163);

    // Random traffic with small divisors so fractions and wraps happen often
    for (int i = 0; i < 8000; i++) begin
      rn = ($urandom_range(0, 499) != 0);
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 59) == 0);
      di = $urandom_range(0, 12);
      df = $urandom_range(0, 15);
      cycle(rn, en, ld, di, df, rs);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
